inst_window_fifo: RTL
=====================

Name: inst_window_fifo

Overview:
Parametrised in-flight instruction window for the pipelined RiSC-16 core and its checkers.
- Records (pc, instruction) at fetch and retires the oldest entry at writeback commit.
- Squashes the N youngest entries on a control-flow redirect.
- Gives commit-side logic (trace, lockstep checker, debug) the exact committed instruction.
- Generalises a fixed 16-bit, unbounded software queue to configurable width, depth, squash and overflow/underflow reporting.

Parameters:
- p_WORD_LEN, 16, instruction width in bits.
- p_PC_LEN, 16, program-counter width in bits.
- p_DEPTH, 8, number of entries; power of two, minimum 2.
- p_CNT_LEN, $clog2(p_DEPTH+1), width of count and squash fields (derived, not overridden).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_push  in  1  append entry at tail (fetch issued, not stalled).
- i_push_pc  in  p_PC_LEN  PC of pushed instruction.
- i_push_inst  in  p_WORD_LEN  pushed instruction word.
- i_pop  in  1  retire head entry (writeback commit).
- o_head_pc  out  p_PC_LEN  PC of oldest entry; 0 when empty.
- o_head_inst  out  p_WORD_LEN  oldest instruction; 0 when empty.
- i_squash  in  1  discard youngest entries.
- i_squash_cnt  in  p_CNT_LEN  number of youngest entries to discard.
- o_count  out  p_CNT_LEN  current occupancy.
- o_empty  out  1  occupancy == 0.
- o_full  out  1  occupancy == p_DEPTH.
- o_overflow  out  1  sticky: push dropped.
- o_underflow  out  1  sticky: pop on empty, or squash exceeding occupancy.

Behaviour:
- Reset (i_rst low, async):
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - o_empty = 1, o_full = 0, head outputs = 0, sticky flags = 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries immediately.
- Storage: p_DEPTH-entry array of {pc, inst}. Pointers are $clog2(p_DEPTH) bits and wrap modulo p_DEPTH naturally.
- Head is first-word-fall-through: o_head_* is a combinational read at rd_ptr, gated to 0 when count == 0. A pushed entry is visible at the head on the cycle after the push edge.
- Per rising edge, operations apply in this order, all using pre-edge state:
  1. Pop:
     - if count > 0: rd_ptr++ and count--.
     - else: ignored, o_underflow set.
  2. Squash, with n = i_squash_cnt and c = count after step 1:
     - if n <= c: wr_ptr -= n, count -= n.
     - else: wr_ptr = rd_ptr (post-pop), count = 0, o_underflow set.
     - n == 0 is a no-op.
  3. Push:
     - accepted if count after steps 1–2 < p_DEPTH: write at wr_ptr, wr_ptr++, count++.
     - else: dropped, o_overflow set.
- Consequences of the ordering:
  - Push and pop together while full: accepted, count unchanged.
  - Push and squash together: the new entry survives; the squash only hits older entries.
  - Pop and squash together: the pop retires the oldest; the squash removes from the tail.
- o_full and o_empty are decoded from the registered count, so they have no combinational path from the inputs.
- Sticky flags clear only on reset.
- No other state machine beyond the pointers, count and flags. Latency push→head is 1 cycle when the window was empty.

Decomposition:
- Shared package risc16_pkg:
  - entry struct (pc, inst) typedef.
  - opcode enum (ADD, ADDI, NAND, LUI, SW, LW, BEQ, JALR = 0..7).
  - default widths.
- One natural sub-module, ptr_ring: a parametrised wrapping pointer with increment and subtract-by-n. Instantiate it twice, for rd_ptr and wr_ptr.
- Storage stays inline as a register array, not a memory macro, because of the async reset and combinational read.

Test Plan:
- Reset then idle → o_empty = 1, o_count = 0, o_head_pc = 0, o_head_inst = 0, both flags = 0.
- Push pc 0x0000..0x0007 with inst 0xA000+i (p_DEPTH = 8) → o_full = 1, o_count = 8, head = (0x0000, 0xA000). A 9th push with no pop → dropped, o_overflow = 1, count stays 8.
- Full window, push pc 0x0008 together with pop → count 8, head = (0x0001, 0xA001). Drain 8 pops → head sequence pc 1..8 in order across the pointer wrap.
- 5 entries (pc 10..14), squash_cnt = 2 together with push pc 0x0040 → count 4, entries pc 10, 11, 12, 0x40. Pop order confirms pc 13 and 14 are gone.
- 3 entries, pop + squash_cnt = 3 → count 0, o_empty = 1, o_underflow = 1. A later push of pc 0x0020 → head = 0x0020, count 1.
- Assert i_rst low mid-stream with 6 entries, asynchronously between edges → outputs go to reset values without waiting for a clock edge. After release, pushes resume at slot 0.

Source files
------------

// File: rtl/risc16_pkg.sv
// Shared RiSC-16 types: default widths, opcode encoding and the (pc, inst) window entry.
package risc16_pkg;

   localparam int c_WORD_LEN = 16;
   localparam int c_PC_LEN   = 16;
   localparam int c_DEPTH    = 8;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_ADDI = 3'd1,
      OP_NAND = 3'd2,
      OP_LUI  = 3'd3,
      OP_SW   = 3'd4,
      OP_LW   = 3'd5,
      OP_BEQ  = 3'd6,
      OP_JALR = 3'd7
   } opcode_e;

   typedef struct packed {
      logic [c_PC_LEN-1:0]   pc;
      logic [c_WORD_LEN-1:0] inst;
   } entry_t;

   function automatic opcode_e opcode_of(input logic [c_WORD_LEN-1:0] inst);
      return opcode_e'(inst[c_WORD_LEN-1 -: 3]);
   endfunction

endpackage

// File: rtl/ptr_ring.sv
// Wrapping ring pointer: next = (load ? load_val : ptr - sub) + inc, modulo p_DEPTH.
// o_base is the combinational pre-increment value, used as the write slot for this cycle.
module ptr_ring #(
   parameter int  p_DEPTH = 8,
   localparam int c_PW    = $clog2(p_DEPTH)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_load,
   input  logic [c_PW-1:0] i_load_val,
   input  logic [c_PW-1:0] i_sub,
   input  logic            i_inc,
   output logic [c_PW-1:0] o_ptr,
   output logic [c_PW-1:0] o_base
);

   logic [c_PW-1:0] ptr;

   assign o_base = i_load ? i_load_val : (ptr - i_sub);
   assign o_ptr  = ptr;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) ptr <= '0;
      else        ptr <= o_base + c_PW'(i_inc);
   end

endmodule

// File: rtl/inst_window_fifo.sv
// In-flight (pc, inst) window: push at fetch, pop at commit, squash youngest on redirect.
// Head is fall-through (push visible next cycle); full pushes drop and set sticky o_overflow.
module inst_window_fifo
   import risc16_pkg::*;
#(
   parameter int  p_WORD_LEN = c_WORD_LEN,
   parameter int  p_PC_LEN   = c_PC_LEN,
   parameter int  p_DEPTH    = c_DEPTH,
   localparam int p_CNT_LEN  = $clog2(p_DEPTH + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_push,
   input  logic [p_PC_LEN-1:0]   i_push_pc,
   input  logic [p_WORD_LEN-1:0] i_push_inst,
   input  logic                  i_pop,
   output logic [p_PC_LEN-1:0]   o_head_pc,
   output logic [p_WORD_LEN-1:0] o_head_inst,
   input  logic                  i_squash,
   input  logic [p_CNT_LEN-1:0]  i_squash_cnt,
   output logic [p_CNT_LEN-1:0]  o_count,
   output logic                  o_empty,
   output logic                  o_full,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam int                   c_PW   = $clog2(p_DEPTH);
   localparam logic [p_CNT_LEN-1:0] c_FULL = p_CNT_LEN'(p_DEPTH);

   typedef struct packed {
      logic [p_PC_LEN-1:0]   pc;
      logic [p_WORD_LEN-1:0] inst;
   } win_entry_t;

   win_entry_t           mem [p_DEPTH];
   logic [p_CNT_LEN-1:0] count;
   logic [c_PW-1:0]      rd_ptr, rd_base, rd_post, wr_ptr, wr_base;

   logic                 pop_ok, push_ok, sq_over;
   logic [p_CNT_LEN-1:0] sq_n, cnt_pop, cnt_sq, cnt_nxt;

   // Pop, then squash, then push, all against pre-edge state.
   always_comb begin
      pop_ok  = i_pop && (count != '0);
      cnt_pop = count - p_CNT_LEN'(pop_ok);
      sq_n    = i_squash ? i_squash_cnt : '0;
      sq_over = (sq_n > cnt_pop);
      cnt_sq  = sq_over ? '0 : (cnt_pop - sq_n);
      push_ok = i_push && (cnt_sq < c_FULL);
      cnt_nxt = cnt_sq + p_CNT_LEN'(push_ok);
   end

   assign rd_post = rd_ptr + c_PW'(pop_ok);

   ptr_ring #(.p_DEPTH(p_DEPTH)) u_rd_ring (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (1'b0),
      .i_load_val ('0),
      .i_sub      ('0),
      .i_inc      (pop_ok),
      .o_ptr      (rd_ptr),
      .o_base     (rd_base)
   );

   // An over-squash collapses the tail back onto the post-pop head.
   ptr_ring #(.p_DEPTH(p_DEPTH)) u_wr_ring (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (sq_over),
      .i_load_val (rd_post),
      .i_sub      (sq_n[c_PW-1:0]),
      .i_inc      (push_ok),
      .o_ptr      (wr_ptr),
      .o_base     (wr_base)
   );

   always_ff @(posedge i_clk) begin
      if (push_ok) mem[wr_base] <= '{pc: i_push_pc, inst: i_push_inst};
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         count       <= '0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         count <= cnt_nxt;
         if (i_push && !push_ok)                       o_overflow  <= 1'b1;
         if ((i_pop && count == '0) || sq_over)        o_underflow <= 1'b1;
      end
   end

   assign o_count     = count;
   assign o_empty     = (count == '0);
   assign o_full      = (count == c_FULL);
   assign o_head_pc   = o_empty ? '0 : mem[rd_base].pc;
   assign o_head_inst = o_empty ? '0 : mem[rd_base].inst;

endmodule
